// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: program load port, run control and the instruction
// stream presented to the CPU. The slave modport is the fetch unit itself;
// the master modport is the host or testbench that loads and controls it.
interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
);
  logic                   load_en;
  logic [PC_BITS-1:0]     load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   start;
  logic                   stop;
  logic                   stall;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [PC_BITS-1:0]     pc;
  logic                   halted;
  logic                   load_err;

  modport slave (
    input  load_en, load_addr, load_data, start, stop, stall,
    output instruction, instr_valid, pc, halted, load_err
  );

  modport master (
    output load_en, load_addr, load_data, start, stop, stall,
    input  instruction, instr_valid, pc, halted, load_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction source for simple_cpu: loadable program memory, pc and slot counter.
// Latency: instruction is a combinational read of mem[pc]; each word is shown for CPI cycles.
// Backpressure: stall freezes slot and pc; stop aborts to IDLE; loads are refused while running.
module instr_fetch #(
  parameter int         INSTR_WIDTH = 20,
  parameter int         PC_BITS     = 5,
  parameter int         CPI         = 3,
  parameter logic [3:0] HALT_OP     = 4'hF
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** PC_BITS;

  state_t                 r_state;
  logic [PC_BITS-1:0]     r_pc;
  logic [3:0]             r_slot;
  logic                   r_valid;
  logic                   r_halted;
  logic                   r_load_err;
  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

  logic [INSTR_WIDTH-1:0] w_word;
  logic                   w_last_slot;
  logic                   w_halt_op;
  logic                   w_load_ok;

  assign w_word      = r_mem[r_pc];
  assign w_last_slot = (r_slot == 4'(CPI - 1));
  assign w_halt_op   = (w_word[INSTR_WIDTH-1 -: 4] == HALT_OP);
  // Program writes are only accepted while the CPU is not consuming the memory.
  assign w_load_ok   = bus.load_en && (r_state != S_RUN);

  assign bus.instruction = r_valid ? w_word : '0;
  assign bus.instr_valid = r_valid;
  assign bus.pc          = r_pc;
  assign bus.halted      = r_halted;
  assign bus.load_err    = r_load_err;

  // Program memory write port; contents survive reset so a program can be replayed.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Flag a refused load one cycle after it was attempted during RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= bus.load_en && (r_state == S_RUN);
    end
  end

  // Fetch FSM: stop beats everything, then HALT detection, then normal slot/pc advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_slot   <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.stop) begin
            r_state  <= S_RUN;
            r_pc     <= '0;
            r_slot   <= '0;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end
        end

        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_slot  <= '0;
            r_valid <= 1'b0;
          end else if (!bus.stall) begin
            if (!w_last_slot) begin
              r_slot <= r_slot + 4'd1;
            end else if (w_halt_op) begin
              // pc parks on the HALT word so the host can see where the program ended.
              r_state  <= S_HALT;
              r_slot   <= '0;
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_slot <= '0;
              r_pc   <= r_pc + 1'b1;
            end
          end
        end

        S_HALT: begin
          if (bus.stop) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_slot   <= '0;
            r_halted <= 1'b0;
          end else if (bus.start) begin
            r_state  <= S_RUN;
            r_pc     <= '0;
            r_slot   <= '0;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end
        end

        default: begin
          r_state  <= S_IDLE;
          r_pc     <= '0;
          r_slot   <= '0;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed table for the load-and-run sequence, hand-written
// corner sequences, then randomized traffic checked every cycle against a
// presentation-countdown model of the fetch unit.
module tb_instr_fetch;

  localparam int CPI = 3;

  logic clk;
  logic rst;

  instr_fetch_if #(.INSTR_WIDTH(20), .PC_BITS(5)) bus ();

  instr_fetch #(
    .INSTR_WIDTH(20),
    .PC_BITS    (5),
    .CPI        (CPI),
    .HALT_OP    (4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0=IDLE 1=RUN 2=HALT; m_rem counts cycles left for the current word.
  int          m_state;
  int          m_pc;
  int          m_rem;
  logic        m_lerr;
  logic [19:0] m_mem [32];

  typedef struct {
    logic        start;
    logic        stop;
    logic        stall;
    logic [19:0] e_instr;
    logic        e_valid;
    logic [4:0]  e_pc;
    logic        e_halted;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 0;
    m_rem   = CPI;
    m_lerr  = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic sl, input logic le,
                            input logic [4:0] la, input logic [19:0] ld);
    logic running;
    running = (m_state == 1);
    m_lerr  = le && running;
    case (m_state)
      0: if (st && !sp) begin
        m_state = 1; m_pc = 0; m_rem = CPI;
      end
      1: if (sp) begin
        m_state = 0; m_pc = 0;
      end else if (!sl) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_mem[m_pc][19:16] == 4'hF) begin
            m_state = 2;
          end else begin
            m_pc  = (m_pc + 1) % 32;
            m_rem = CPI;
          end
        end
      end
      default: if (sp) begin
        m_state = 0; m_pc = 0;
      end else if (st) begin
        m_state = 1; m_pc = 0; m_rem = CPI;
      end
    endcase
    if (le && !running) m_mem[la] = ld;
  endtask

  task automatic compare_model();
    logic [19:0] e_instr;
    e_instr = (m_state == 1) ? m_mem[m_pc] : 20'h0;
    chk("instruction", 32'(bus.instruction), 32'(e_instr));
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_state == 1));
    chk("pc",          32'(bus.pc),          32'(m_pc));
    chk("halted",      32'(bus.halted),      32'(m_state == 2));
    chk("load_err",    32'(bus.load_err),    32'(m_lerr));
  endtask

  task automatic step(input logic st, input logic sp, input logic sl, input logic le,
                      input logic [4:0] la, input logic [19:0] ld);
    @(negedge clk);
    bus.start     = st;
    bus.stop      = sp;
    bus.stall     = sl;
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    @(posedge clk);
    model_edge(st, sp, sl, le, la, ld);
    #1;
    compare_model();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
  endtask

  task automatic load_program();
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 20'h10203);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 20'h20401);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 20'hF0000);
  endtask

  task automatic run_to_halt(input string name);
    int n;
    n = 0;
    while (!bus.halted && n < 200) begin
      idle_step();
      n++;
    end
    chk(name, 32'(bus.halted), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 20'h10203, 1'b1, 5'd0, 1'b0};
    tbl[0].start = 1'b1;
    for (int i = 3; i < 6; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 20'h20401, 1'b1, 5'd1, 1'b0};
    for (int i = 6; i < 9; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 20'hF0000, 1'b1, 5'd2, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 20'h00000, 1'b0, 5'd2, 1'b1};

    rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.stall = 1'b0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 20'h0;
    #12;
    compare_model();
    @(negedge clk);
    rst = 1'b1;

    // Fill memory with known non-HALT words so every model read is defined.
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), {4'h1, 16'(i)});
    load_program();

    // Load and run: each word held for CPI cycles, then HALT at pc=2.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].start, tbl[i].stop, tbl[i].stall, 1'b0, 5'd0, 20'h0);
      chk("tbl_instr",  32'(bus.instruction), 32'(tbl[i].e_instr));
      chk("tbl_valid",  32'(bus.instr_valid), 32'(tbl[i].e_valid));
      chk("tbl_pc",     32'(bus.pc),          32'(tbl[i].e_pc));
      chk("tbl_halted", 32'(bus.halted),      32'(tbl[i].e_halted));
    end

    // Stall at pc=1, slot=1 for 4 cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    repeat (4) idle_step();
    chk("stall_pre_pc", 32'(bus.pc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 20'h0);
      chk("stall_pc",    32'(bus.pc),          32'd1);
      chk("stall_instr", 32'(bus.instruction), 32'h20401);
    end
    idle_step();
    chk("stall_rel1_pc", 32'(bus.pc), 32'd1);
    idle_step();
    chk("stall_rel2_pc", 32'(bus.pc), 32'd2);
    run_to_halt("stall_halt");

    // Stop together with start at the last slot of pc=1: stop wins, no advance.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    repeat (5) idle_step();
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 20'h0);
    chk("stop_valid", 32'(bus.instr_valid), 32'd0);
    chk("stop_pc",    32'(bus.pc),          32'd0);
    chk("stop_halt",  32'(bus.halted),      32'd0);

    // Load while running is dropped and flagged for one cycle.
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 20'hABCDE);
    chk("lerr_pulse", 32'(bus.load_err), 32'd1);
    idle_step();
    chk("lerr_clear", 32'(bus.load_err), 32'd0);
    run_to_halt("lerr_halt");
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    chk("lerr_mem0", 32'(bus.instruction), 32'h10203);

    // Wrap-around with no HALT words anywhere.
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 20'h0);
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), {4'(i % 14), 16'(i * 7)});
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    for (int i = 1; i < 32 * CPI + 1; i++) idle_step();
    chk("wrap_pc",    32'(bus.pc),          32'd0);
    chk("wrap_valid", 32'(bus.instr_valid), 32'd1);
    chk("wrap_halt",  32'(bus.halted),      32'd0);

    // Asynchronous reset mid-run at pc=1, then replay.
    step(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 20'h0);
    load_program();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    repeat (3) idle_step();
    chk("arst_pre_pc", 32'(bus.pc), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_instr", 32'(bus.instruction), 32'h0);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_pc",    32'(bus.pc),          32'd0);
    chk("arst_halt",  32'(bus.halted),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 20'h0);
    chk("arst_replay", 32'(bus.instruction), 32'h10203);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic        st, sp, sl, le;
      logic [4:0]  la;
      logic [19:0] ld;
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 39) == 0);
      sl = ($urandom_range(0, 4) == 0);
      le = ($urandom_range(0, 6) == 0);
      la = 5'($urandom_range(0, 31));
      ld = 20'($urandom);
      if (ld[19:16] == 4'hF && $urandom_range(0, 3) != 0) ld[19:16] = 4'h3;
      step(st, sp, sl, le, la, ld);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
